maze_cursor_ctrl: RTL and testbench

Upstream position stage for the maze mini-game: turns the four push-buttons into the player cell index `count` (0–197 on an 18×11 grid, `row*18+col`) that the red-square renderer and checkpoint logic consume. It steps one cell per 10 Hz tick and checks every step against `mazestate`. On a wall collision it emits the tower code 255 for a fixed number of ticks, then respawns the player at the renderer-supplied `begin_spot`.

---
 rtl/maze_cursor_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_maze_cursor_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/maze_cursor_ctrl.sv
// maze_cursor_ctrl
//   Converts the four push-buttons into the player cell index on a
//   COLS x ROWS maze grid (index = row*COLS + col). One step is taken per
//   tick, and every step is checked against the maze wall map. Walking into
//   a wall shows the tower code 255 for HIT_TICKS ticks. The player then
//   respawns at begin_spot, or at START_CELL if begin_spot is off the grid.
//
//   Optional feature: define MAZE_CURSOR_AUTOREPEAT_EN to let a held button
//   re-arm its step on every tick, starting with the REPEAT_DELAY-th tick
//   after the press.
//
// Ports
//   CLK         in   system clock
//   RESET       in   asynchronous active-low reset
//   tick        in   one-CLK-wide step strobe (10 Hz)
//   btnU/D/L/R  in   raw asynchronous buttons
//   mazestate   in   bit n = 1 -> cell n is path, 0 -> wall
//   begin_spot  in   respawn cell
//   count       out  player cell, 255 while hit
//   hit         out  high while in the hit state
//   move_pulse  out  one-cycle strobe per accepted step
module maze_cursor_ctrl #(
  parameter int COLS         = 18,
  parameter int ROWS         = 11,
  parameter int START_CELL   = 181,
  parameter int HIT_TICKS    = 5,
  parameter int REPEAT_DELAY = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 tick,
  input  logic                 btnU,
  input  logic                 btnD,
  input  logic                 btnL,
  input  logic                 btnR,
  input  logic [COLS*ROWS-1:0] mazestate,
  input  logic [7:0]           begin_spot,
  output logic [7:0]           count,
  output logic                 hit,
  output logic                 move_pulse
);

  localparam logic [7:0] C_COLS  = 8'(COLS);
  localparam logic [7:0] C_LAST  = 8'(COLS*ROWS-1);
  localparam logic [7:0] C_START = 8'(START_CELL);
  localparam logic [7:0] C_TOWER = 8'd255;
  localparam int         HCW     = $clog2(HIT_TICKS+1);

  typedef enum logic [1:0] {S_PLAY = 2'd0, S_HIT = 2'd1, S_RESPAWN = 2'd2} state_t;

  state_t           r_state;
  logic [7:0]       r_count;
  logic             r_hit;
  logic             r_move;
  logic [3:0]       r_pend;   // bit 3 = U, 2 = D, 1 = L, 0 = R
  logic [HCW-1:0]   r_hitcnt;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_prev;

  logic [3:0]       w_rise;
  logic [3:0]       w_rearm;
  logic [7:0]       w_row;
  logic [7:0]       w_col;
  logic [7:0]       w_target;
  logic [7:0]       w_idx;
  logic             w_edge;
  logic             w_open;
  logic [HCW-1:0]   w_hit_next;

  // Row from cell index by comparing against row-start thresholds (no divider).
  function automatic logic [7:0] row_of(input logic [7:0] c);
    logic [7:0] r;
    r = 8'd0;
    for (int k = 1; k < ROWS; k++) begin
      if (32'(c) >= 32'(k*COLS)) begin
        r = 8'(k);
      end
    end
    return r;
  endfunction

  // Two-flop synchronizer plus previous-value register for edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_prev  <= 4'b0000;
    end else begin
      r_sync1 <= {btnU, btnD, btnL, btnR};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_hit_next = r_hitcnt + HCW'(1);

`ifdef MAZE_CURSOR_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_DELAY+1);
  logic [RCW-1:0] r_hold [4];

  // Per-button count of ticks seen while held, saturating at REPEAT_DELAY.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int b = 0; b < 4; b++) r_hold[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!r_sync2[b]) begin
          r_hold[b] <= '0;
        end else if (tick && (32'(r_hold[b]) < 32'(REPEAT_DELAY))) begin
          r_hold[b] <= r_hold[b] + RCW'(1);
        end else begin
          r_hold[b] <= r_hold[b];
        end
      end
    end
  end

  // A held button re-arms on the tick that completes the repeat delay.
  always_comb begin
    w_rearm = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      w_rearm[b] = r_sync2[b] && ((32'(r_hold[b]) + 32'd1) >= 32'(REPEAT_DELAY));
    end
  end
`else
  logic w_unused;
  assign w_unused = (REPEAT_DELAY > 0);
  assign w_rearm  = 4'b0000;
`endif

  // Pick the pending direction (U > D > L > R), its target and edge/wall status.
  always_comb begin
    w_row    = row_of(r_count);
    w_col    = r_count - 8'(w_row * C_COLS);
    w_edge   = 1'b0;
    w_target = r_count;
    if (r_pend[3]) begin
      w_edge   = (w_row == 8'd0);
      w_target = r_count - C_COLS;
    end else if (r_pend[2]) begin
      w_edge   = (w_row == 8'(ROWS-1));
      w_target = r_count + C_COLS;
    end else if (r_pend[1]) begin
      w_edge   = (w_col == 8'd0);
      w_target = r_count - 8'd1;
    end else begin
      w_edge   = (w_col == 8'(COLS-1));
      w_target = r_count + 8'd1;
    end
    // Blocked moves never index the map, so the index stays on the grid.
    w_idx  = w_edge ? 8'd0 : w_target;
    w_open = w_edge ? 1'b0 : mazestate[w_idx];
  end

  // Main PLAY / HIT / RESPAWN state machine with registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_PLAY;
      r_count  <= C_START;
      r_hit    <= 1'b0;
      r_move   <= 1'b0;
      r_pend   <= 4'b0000;
      r_hitcnt <= '0;
    end else begin
      r_move <= 1'b0;
      case (r_state)
        S_PLAY: begin
          if (tick) begin
            // Edges arriving with the tick survive for the next tick.
            r_pend <= w_rise | w_rearm;
            if ((r_pend != 4'b0000) && !w_edge) begin
              if (w_open) begin
                r_count <= w_target;
                r_move  <= 1'b1;
              end else begin
                r_count  <= C_TOWER;
                r_hit    <= 1'b1;
                r_hitcnt <= '0;
                r_pend   <= 4'b0000;
                r_state  <= S_HIT;
              end
            end
          end else begin
            r_pend <= r_pend | w_rise;
          end
        end
        S_HIT: begin
          r_pend <= 4'b0000;
          if (tick) begin
            r_hitcnt <= w_hit_next;
            if (w_hit_next == HCW'(HIT_TICKS)) begin
              r_state <= S_RESPAWN;
            end
          end
        end
        S_RESPAWN: begin
          r_count <= (begin_spot > C_LAST) ? C_START : begin_spot;
          r_hit   <= 1'b0;
          r_pend  <= r_pend | w_rise;
          r_state <= S_PLAY;
        end
        default: begin
          r_state <= S_PLAY;
        end
      endcase
    end
  end

  assign count      = r_count;
  assign hit        = r_hit;
  assign move_pulse = r_move;

endmodule

// File: tb/tb_maze_cursor_ctrl.sv
// Directed testbench for maze_cursor_ctrl: walks the cursor through the
// default 18x11 grid, exercising steps, grid edges, wall hits, respawn,
// direction priority, held-button behaviour and reset during a hit.
module tb_maze_cursor_ctrl;

  logic         CLK;
  logic         RESET;
  logic         tick;
  logic         btnU, btnD, btnL, btnR;
  logic [197:0] mazestate;
  logic [7:0]   begin_spot;
  logic [7:0]   count;
  logic         hit;
  logic         move_pulse;

  int n_checks;
  int n_errors;
  int exp_pos;

  maze_cursor_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .tick       (tick),
    .btnU       (btnU),
    .btnD       (btnD),
    .btnL       (btnL),
    .btnR       (btnR),
    .mazestate  (mazestate),
    .begin_spot (begin_spot),
    .count      (count),
    .hit        (hit),
    .move_pulse (move_pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tick pulse; returns at the falling edge after the tick's active edge.
  task automatic do_tick();
    @(negedge CLK) tick = 1'b1;
    @(negedge CLK) tick = 1'b0;
  endtask

  // Press/release the buttons in mask {U,D,L,R}; long enough to become pending.
  task automatic press(input logic [3:0] m);
    @(negedge CLK) {btnU, btnD, btnL, btnR} = m;
    repeat (3) @(negedge CLK);
    {btnU, btnD, btnL, btnR} = 4'b0000;
    @(negedge CLK);
  endtask

  // Called right after the tick that caused the hit; runs through respawn.
  task automatic hit_run(input string tag, input int respawn_exp, input int late_spot);
    check({tag, "_count0"}, 32'(count), 32'd255);
    check({tag, "_hit0"}, 32'(hit), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      if (i == 2) press(4'b1000);
      check({tag, "_count_hold"}, 32'(count), 32'd255);
      check({tag, "_hit_hold"}, 32'(hit), 32'd1);
    end
    begin_spot = 8'(late_spot);
    do_tick();
    check({tag, "_count_last"}, 32'(count), 32'd255);
    @(negedge CLK);
    check({tag, "_respawn"}, 32'(count), 32'(respawn_exp));
    check({tag, "_hit_clr"}, 32'(hit), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    RESET      = 1'b0;
    tick       = 1'b0;
    {btnU, btnD, btnL, btnR} = 4'b0000;
    mazestate  = '1;
    begin_spot = 8'd31;
    repeat (3) @(negedge CLK);
    check("rst_count", 32'(count), 32'd181);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_move", 32'(move_pulse), 32'd0);
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) do_tick();
    check("idle_count", 32'(count), 32'd181);

    // Basic steps.
    press(4'b1000); do_tick();
    check("up_count", 32'(count), 32'd163);
    check("up_move", 32'(move_pulse), 32'd1);
    @(negedge CLK);
    check("up_move_1cyc", 32'(move_pulse), 32'd0);
    press(4'b0100); do_tick();
    check("down_count", 32'(count), 32'd181);
    press(4'b0010); do_tick();
    check("left_count", 32'(count), 32'd180);
    // Column 0 edge.
    press(4'b0010); do_tick();
    check("edgeL_count", 32'(count), 32'd180);
    check("edgeL_move", 32'(move_pulse), 32'd0);
    press(4'b0001); do_tick();
    check("right_count", 32'(count), 32'd181);

    // Wall hit; begin_spot changes during HIT, the respawn-time value wins.
    mazestate[180] = 1'b0;
    begin_spot = 8'd99;
    press(4'b0010); do_tick();
    hit_run("hit31", 31, 31);
    do_tick();
    check("hit31_no_late_press", 32'(count), 32'd31);
    check("hit31_no_late_move", 32'(move_pulse), 32'd0);

    // Off-grid respawn spot falls back to the start cell.
    mazestate[13] = 1'b0;
    press(4'b1000); do_tick();
    hit_run("hit200", 181, 200);

    // Respawn at 17 (row 0, col 17) to test the top and right edges.
    press(4'b0010); do_tick();
    hit_run("hit17", 17, 17);
    press(4'b1000); do_tick();
    check("edgeU_count", 32'(count), 32'd17);
    check("edgeU_move", 32'(move_pulse), 32'd0);
    press(4'b0001); do_tick();
    check("edgeR_count", 32'(count), 32'd17);

    // Respawn at 163, then U and R together: only U is taken.
    mazestate[16] = 1'b0;
    press(4'b0010); do_tick();
    hit_run("hit163", 163, 163);
    press(4'b1001); do_tick();
    check("prio_count", 32'(count), 32'd145);
    do_tick();
    check("prio_r_dropped", 32'(count), 32'd145);

    // Respawn at 126, then hold R across five ticks.
    mazestate[144] = 1'b0;
    press(4'b0010); do_tick();
    hit_run("hit126", 126, 126);
    @(negedge CLK) btnR = 1'b1;
    repeat (4) @(negedge CLK);
    do_tick(); check("hold_t1", 32'(count), 32'd127);
    do_tick(); check("hold_t2", 32'(count), 32'd127);
    do_tick(); check("hold_t3", 32'(count), 32'd127);
`ifdef MAZE_CURSOR_AUTOREPEAT_EN
    do_tick(); check("hold_t4", 32'(count), 32'd128);
    do_tick(); check("hold_t5", 32'(count), 32'd129);
    exp_pos = 129;
`else
    do_tick(); check("hold_t4", 32'(count), 32'd127);
    do_tick(); check("hold_t5", 32'(count), 32'd127);
    exp_pos = 127;
`endif
    btnR = 1'b0;
    repeat (4) @(negedge CLK);

    // Reset in the middle of a hit.
    mazestate[exp_pos+1] = 1'b0;
    press(4'b0001); do_tick();
    check("mid_hit", 32'(hit), 32'd1);
    do_tick();
    RESET = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd181);
    check("mid_rst_hit", 32'(hit), 32'd0);
    @(negedge CLK) RESET = 1'b1;
    do_tick();
    check("post_rst_count", 32'(count), 32'd181);
    check("post_rst_hit", 32'(hit), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
